// File: rtl/par2ser_pkg.sv
// Shared types for the parallel-to-serial converter.
package par2ser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam bit CNT_UP = 1'b1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/par2ser_if.sv
// Word-in / bit-out handshake bundle for par2ser.
interface par2ser_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic             din_rdy;
  logic             dout;
  logic             dout_vld;
  logic             dout_rdy;

  modport master (
    output din, din_vld, din_rdy,
    input  dout, dout_vld, dout_rdy
  );

  modport slave (
    input  din, din_vld, din_rdy,
    output dout, dout_vld, dout_rdy
  );
endinterface

// File: rtl/par2ser_counter.sv
// Wrapping bit-index counter; cnt_last_o flags the terminal index.
module par2ser_counter
  import par2ser_pkg::*;
#(
  parameter int CNT_NUM = 8,
  parameter bit UP      = CNT_UP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_cnt_i,
  output logic cnt_last_o
);

  localparam int CW = cnt_w(CNT_NUM);
  localparam logic [CW-1:0] FIRST = UP ? '0 : CW'(CNT_NUM - 1);
  localparam logic [CW-1:0] LAST  = UP ? CW'(CNT_NUM - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_cnt_i) begin
      if (cnt_q == LAST) begin
        cnt_d = FIRST;
      end else if (UP) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= FIRST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_last_o = (cnt_q == LAST);

endmodule

// File: rtl/par2ser.sv
// Parallel-to-serial converter with a one-word holding buffer for gapless streaming.
module par2ser
  import par2ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  par2ser_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             cnt_last;
  logic             bit_xfer;
  logic             word_acc;

  assign bus.dout_vld = (state_q == ST_SHIFT);
  assign bus.dout_rdy = ~hold_full_q;
  assign bus.dout     = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];

  assign bit_xfer = bus.dout_vld & bus.din_rdy;
  assign word_acc = bus.din_vld & bus.dout_rdy;

  par2ser_counter #(
    .CNT_NUM (WIDTH),
    .UP      (CNT_UP)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_cnt_i   (bit_xfer),
    .cnt_last_o (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    unique case (state_q)
      ST_IDLE: begin
        if (word_acc) begin
          sr_d    = bus.din;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_xfer && cnt_last) begin
          // Held word wins over a same-cycle accept; dout_rdy is low then anyway.
          if (hold_full_q) begin
            sr_d        = hold_q;
            hold_full_d = 1'b0;
          end else if (word_acc) begin
            sr_d = bus.din;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (bit_xfer) begin
            sr_d = LSB_FIRST ? {1'b0, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], 1'b0};
          end
          if (word_acc) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule
